// File: rtl/lcd_status_writer.sv
// lcd_status_writer
//
// Builds a 32-character, two-line status page
// ("PLAYER <n1><n2>", "SCORE <hundreds><tens><units>") and streams it to a
// slow character-LCD controller. A page is rewritten after reset and
// whenever the name or score input differs from what is on the display.
//
// Ports:
//   clock       system clock
//   resetn      asynchronous active-low reset
//   name[15:0]  two ASCII characters, [15:8] first; 8'h00 shows as a blank
//   score[7:0]  unsigned score 0..255, shown in decimal
//   ascii_data  character to the controller; holds its value between writes
//   lcd_we      one-cycle write strobe
//   lcd_reset   one-cycle clear/home strobe
//   busy        high for the whole duration of a page refresh
//   fsm_state   current FSM state, for observation only
//
// Strobe protocol: there is no backpressure. lcd_reset and lcd_we are
// single-cycle pulses, and ascii_data is valid in the same cycle as lcd_we.
// After every pulse the block idles for GAP cycles, so the controller must
// accept one command per GAP+1 cycles.

module lcd_status_writer #(
  parameter int GAP = 50000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [15:0] name,
  input  logic [7:0]  score,
  output logic [7:0]  ascii_data,
  output logic        lcd_we,
  output logic        lcd_reset,
  output logic        busy,
  output logic [2:0]  fsm_state
);

  localparam logic [19:0] GAP_LOAD = 20'(GAP);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONVERT = 3'd1,
    CLEAR   = 3'd2,
    WAIT    = 3'd3,
    SEND    = 3'd4
  } state_t;

  state_t      state;
  logic        pending;
  logic [15:0] snap_name;
  logic [7:0]  snap_score;
  logic [19:0] dd;        // double-dabble register: {hund, tens, units, binary}
  logic [2:0]  cnv_cnt;
  logic [19:0] gap_cnt;
  logic [5:0]  idx;       // page position 0..32; 32 means the page is done

  assign fsm_state = state;

  // One double-dabble step: add 3 to any BCD digit >= 5, then shift left.
  logic [19:0] dd_adj;
  logic [19:0] dd_next;

  always_comb begin
    dd_adj = dd;
    if (dd[11:8]  >= 4'd5) dd_adj[11:8]  = dd[11:8]  + 4'd3;
    if (dd[15:12] >= 4'd5) dd_adj[15:12] = dd[15:12] + 4'd3;
    if (dd[19:16] >= 4'd5) dd_adj[19:16] = dd[19:16] + 4'd3;
    dd_next = {dd_adj[18:0], 1'b0};
  end

  // After eight steps the three BCD digits sit in dd[19:8].
  logic [3:0] hund;
  logic [3:0] tens;
  logic [3:0] units;
  logic [7:0] hund_c;
  logic [7:0] tens_c;
  logic [7:0] units_c;
  logic [7:0] name_hi;
  logic [7:0] name_lo;

  assign hund  = dd[19:16];
  assign tens  = dd[15:12];
  assign units = dd[11:8];

  // Leading-zero blanking: hundreds when zero, tens only when both are zero.
  assign hund_c  = (hund == 4'd0) ? 8'h20 : {4'h3, hund};
  assign tens_c  = (hund == 4'd0 && tens == 4'd0) ? 8'h20 : {4'h3, tens};
  assign units_c = {4'h3, units};

  assign name_hi = (snap_name[15:8] == 8'h00) ? 8'h20 : snap_name[15:8];
  assign name_lo = (snap_name[7:0]  == 8'h00) ? 8'h20 : snap_name[7:0];

  logic [7:0] page_char;

  always_comb begin
    page_char = 8'h20;
    case (idx)
      6'd0:    page_char = "P";
      6'd1:    page_char = "L";
      6'd2:    page_char = "A";
      6'd3:    page_char = "Y";
      6'd4:    page_char = "E";
      6'd5:    page_char = "R";
      6'd7:    page_char = name_hi;
      6'd8:    page_char = name_lo;
      6'd16:   page_char = "S";
      6'd17:   page_char = "C";
      6'd18:   page_char = "O";
      6'd19:   page_char = "R";
      6'd20:   page_char = "E";
      6'd22:   page_char = hund_c;
      6'd23:   page_char = tens_c;
      6'd24:   page_char = units_c;
      default: page_char = 8'h20;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      pending    <= 1'b1;
      snap_name  <= 16'h0000;
      snap_score <= 8'h00;
      dd         <= 20'h00000;
      cnv_cnt    <= 3'd0;
      gap_cnt    <= 20'h00000;
      idx        <= 6'd0;
      ascii_data <= 8'h20;
      lcd_we     <= 1'b0;
      lcd_reset  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Inputs are compared against the last snapshot only here, so any
          // change made during a refresh is picked up once it finishes.
          if (pending || ({name, score} != {snap_name, snap_score})) begin
            snap_name  <= name;
            snap_score <= score;
            dd         <= {12'h000, score};
            cnv_cnt    <= 3'd0;
            pending    <= 1'b0;
            busy       <= 1'b1;
            state      <= CONVERT;
          end
        end

        CONVERT: begin
          dd      <= dd_next;
          cnv_cnt <= cnv_cnt + 3'd1;
          if (cnv_cnt == 3'd7) begin
            lcd_reset <= 1'b1;
            state     <= CLEAR;
          end
        end

        CLEAR: begin
          lcd_reset <= 1'b0;
          gap_cnt   <= GAP_LOAD;
          idx       <= 6'd0;
          state     <= WAIT;
        end

        WAIT: begin
          // The counter is loaded with GAP on entry, so leaving at 1 gives
          // exactly GAP cycles in this state.
          if (gap_cnt == 20'd1) begin
            if (idx == 6'd32) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              lcd_we     <= 1'b1;
              ascii_data <= page_char;
              state      <= SEND;
            end
          end else begin
            gap_cnt <= gap_cnt - 20'd1;
          end
        end

        SEND: begin
          lcd_we  <= 1'b0;
          idx     <= idx + 6'd1;
          gap_cnt <= GAP_LOAD;
          state   <= WAIT;
        end

        default: begin
          lcd_we    <= 1'b0;
          lcd_reset <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_status_writer.sv
// tb_lcd_status_writer
//
// Bench for lcd_status_writer with GAP = 4. Every page the bench expects is
// pushed into exp_q at the moment the inputs are changed; a monitor pops one
// entry per lcd_we pulse and compares it with ascii_data. The monitor also
// checks strobe spacing and lcd_reset placement relative to busy rising.

module tb_lcd_status_writer;

  localparam int GAP = 4;
  localparam int REFRESH_CYCLES = 9 + 32 * (GAP + 1) + GAP;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] name = 16'h0000;
  logic [7:0]  score = 8'h00;
  logic [7:0]  ascii_data;
  logic        lcd_we;
  logic        lcd_reset;
  logic        busy;
  logic [2:0]  fsm_state;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  lcd_status_writer #(.GAP(GAP)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .name       (name),
    .score      (score),
    .ascii_data (ascii_data),
    .lcd_we     (lcd_we),
    .lcd_reset  (lcd_reset),
    .busy       (busy),
    .fsm_state  (fsm_state)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] model_char(input int k, input logic [15:0] n,
                                            input logic [7:0] s);
    int h;
    int t;
    int u;
    logic [7:0] c;
    h = s / 100;
    t = (s / 10) % 10;
    u = s % 10;
    c = 8'h20;
    case (k)
      0:  c = 8'h50;
      1:  c = 8'h4C;
      2:  c = 8'h41;
      3:  c = 8'h59;
      4:  c = 8'h45;
      5:  c = 8'h52;
      7:  c = (n[15:8] == 8'h00) ? 8'h20 : n[15:8];
      8:  c = (n[7:0] == 8'h00) ? 8'h20 : n[7:0];
      16: c = 8'h53;
      17: c = 8'h43;
      18: c = 8'h4F;
      19: c = 8'h52;
      20: c = 8'h45;
      22: c = (h == 0) ? 8'h20 : 8'(8'h30 + h);
      23: c = (h == 0 && t == 0) ? 8'h20 : 8'(8'h30 + t);
      24: c = 8'(8'h30 + u);
      default: c = 8'h20;
    endcase
    return c;
  endfunction

  task automatic push_page(input logic [15:0] n, input logic [7:0] s);
    for (int k = 0; k < 32; k++) exp_q.push_back(model_char(k, n, s));
  endtask

  // ---------------- monitor ----------------
  int we_count = 0;
  int rst_count = 0;
  int we_in_page = 0;
  int last_we_cyc = 0;
  int last_rst_cyc = 0;
  int rise_cyc = 0;
  bit busy_prev = 0;
  bit prev_we = 0;
  bit prev_rst = 0;
  logic [7:0] cap [0:31];

  always @(negedge clock) begin
    if (!resetn) begin
      we_in_page = 0;
      busy_prev = 0;
      prev_we = 0;
      prev_rst = 0;
    end else begin
      if (busy === 1'b1 && !busy_prev) rise_cyc = cyc;
      if (lcd_reset === 1'b1) begin
        rst_count++;
        checks++;
        if (prev_rst || lcd_we !== 1'b0 || (cyc - rise_cyc) != 8) begin
          errors++;
          $display("FAIL lcd_reset_timing: offset=%0d prev_rst=%0d we=%b, required offset=8 single strobe",
                   cyc - rise_cyc, prev_rst, lcd_we);
        end
        we_in_page = 0;
        last_rst_cyc = cyc;
      end
      if (lcd_we === 1'b1) begin
        logic [7:0] exp_c;
        int exp_cyc;
        we_count++;
        exp_cyc = (we_in_page == 0) ? last_rst_cyc + GAP + 1 : last_we_cyc + GAP + 1;
        checks++;
        if (cyc != exp_cyc || prev_we) begin
          errors++;
          $display("FAIL we_spacing: write %0d at cycle %0d prev_we=%0d, required cycle %0d",
                   we_in_page, cyc, prev_we, exp_cyc);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got %h with empty expected queue", ascii_data);
        end else begin
          exp_c = exp_q.pop_front();
          if (ascii_data !== exp_c) begin
            errors++;
            $display("FAIL page_char[%0d]: got %h, required %h", we_in_page, ascii_data, exp_c);
          end
        end
        if (we_in_page < 32) cap[we_in_page] = ascii_data;
        we_in_page++;
        last_we_cyc = cyc;
      end
      busy_prev = (busy === 1'b1);
      prev_we = (lcd_we === 1'b1);
      prev_rst = (lcd_reset === 1'b1);
    end
  end

  // ---------------- driver helpers ----------------
  // Waits for busy to rise, then counts busy-high cycles until it falls.
  task automatic run_refresh(output int busy_cycles);
    int n;
    n = 0;
    busy_cycles = 0;
    while (busy !== 1'b1) begin
      if (n >= 100) begin
        checks++;
        errors++;
        $display("FAIL refresh_start_timeout: busy=%b after %0d cycles, required 1", busy, n);
        return;
      end
      @(negedge clock);
      n++;
    end
    while (busy === 1'b1) begin
      busy_cycles++;
      @(negedge clock);
      if (busy_cycles > 5000) begin
        checks++;
        errors++;
        $display("FAIL refresh_end_timeout: busy still %b, required 0", busy);
        return;
      end
    end
  endtask

  task automatic wait_writes(input int nw);
    int seen;
    int n;
    seen = 0;
    n = 0;
    while (seen < nw) begin
      @(negedge clock);
      n++;
      if (lcd_we === 1'b1) seen++;
      if (n > 3000) begin
        checks++;
        errors++;
        $display("FAIL write_timeout: saw %0d writes, required %0d", seen, nw);
        return;
      end
    end
  endtask

  task automatic wait_busy_low();
    int n;
    n = 0;
    while (busy === 1'b1) begin
      @(negedge clock);
      n++;
      if (n > 3000) begin
        checks++;
        errors++;
        $display("FAIL busy_low_timeout: busy=%b, required 0", busy);
        return;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    name = 16'h4E47;
    score = 8'd0;
    repeat (2) @(negedge clock);
    checks++;
    if (ascii_data !== 8'h20) begin
      errors++;
      $display("FAIL reset_ascii: got %h, required 20", ascii_data);
    end
    checks++;
    if (lcd_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_we: got %b, required 0", lcd_we);
    end
    checks++;
    if (lcd_reset !== 1'b0) begin
      errors++;
      $display("FAIL reset_lcd_reset: got %b, required 0", lcd_reset);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b, required 0", busy);
    end
    push_page(name, score);
    resetn = 1'b1;
  endtask

  task automatic test_power_up();
    int bc;
    int we0;
    int rs0;
    we0 = we_count;
    rs0 = rst_count;
    run_refresh(bc);
    checks++;
    if (bc != REFRESH_CYCLES) begin
      errors++;
      $display("FAIL powerup_busy_len: got %0d, required %0d", bc, REFRESH_CYCLES);
    end
    checks++;
    if (we_count - we0 != 32) begin
      errors++;
      $display("FAIL powerup_we_count: got %0d, required 32", we_count - we0);
    end
    checks++;
    if (rst_count - rs0 != 1) begin
      errors++;
      $display("FAIL powerup_reset_count: got %0d, required 1", rst_count - rs0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL powerup_queue: %0d chars left, required 0", exp_q.size());
    end
  endtask

  task automatic test_decimal();
    logic [7:0] vals [4];
    int bc;
    int we0;
    int rs0;
    int stray;
    vals[0] = 8'd5;
    vals[1] = 8'd40;
    vals[2] = 8'd100;
    vals[3] = 8'd255;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      score = vals[i];
      push_page(name, score);
      we0 = we_count;
      rs0 = rst_count;
      run_refresh(bc);
      checks++;
      if (we_count - we0 != 32 || rst_count - rs0 != 1 || bc != REFRESH_CYCLES) begin
        errors++;
        $display("FAIL decimal_refresh[%0d]: we=%0d rst=%0d busy=%0d, required 32 1 %0d",
                 vals[i], we_count - we0, rst_count - rs0, bc, REFRESH_CYCLES);
      end
      stray = 0;
      repeat (5) begin
        @(negedge clock);
        if (busy !== 1'b0) stray++;
      end
      checks++;
      if (stray != 0) begin
        errors++;
        $display("FAIL decimal_single_refresh[%0d]: busy high %0d cycles, required 0", vals[i], stray);
      end
    end
  endtask

  task automatic test_no_spurious();
    int bad;
    bad = 0;
    repeat (1000) begin
      @(negedge clock);
      if (lcd_we !== 1'b0 || lcd_reset !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL no_spurious: %0d active cycles, required 0", bad);
    end
  endtask

  task automatic test_change_mid();
    int bc;
    int we0;
    we0 = we_count;
    @(negedge clock);
    score = 8'd3;
    push_page(name, 8'd3);
    wait_writes(10);
    score = 8'd9;
    push_page(name, 8'd9);
    wait_busy_low();
    @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL change_mid_restart: busy=%b one cycle after end, required 1", busy);
    end
    run_refresh(bc);
    checks++;
    if (we_count - we0 != 64) begin
      errors++;
      $display("FAIL change_mid_we_count: got %0d, required 64", we_count - we0);
    end
    // 9 -> 12 -> back to 9 while the 12 page is being written.
    we0 = we_count;
    @(negedge clock);
    score = 8'd12;
    push_page(name, 8'd12);
    wait_writes(5);
    score = 8'd9;
    push_page(name, 8'd9);
    wait_busy_low();
    run_refresh(bc);
    checks++;
    if (we_count - we0 != 64 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL change_back_refresh: we=%0d left=%0d, required 64 0",
               we_count - we0, exp_q.size());
    end
  endtask

  task automatic test_null_name();
    int bc;
    @(negedge clock);
    name = 16'h4100;
    push_page(name, score);
    run_refresh(bc);
    checks++;
    if (cap[7] !== 8'h41 || cap[8] !== 8'h20) begin
      errors++;
      $display("FAIL null_name: got %h %h, required 41 20", cap[7], cap[8]);
    end
  endtask

  task automatic test_reset_mid();
    int bc;
    int we0;
    @(negedge clock);
    score = 8'd77;
    push_page(name, score);
    wait_writes(20);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (ascii_data !== 8'h20 || lcd_we !== 1'b0 || lcd_reset !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: data=%h we=%b rst=%b busy=%b, required 20 0 0 0",
               ascii_data, lcd_we, lcd_reset, busy);
    end
    exp_q.delete();
    push_page(name, score);
    repeat (2) @(negedge clock);
    we0 = we_count;
    resetn = 1'b1;
    run_refresh(bc);
    checks++;
    if (we_count - we0 != 32 || bc != REFRESH_CYCLES || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_refresh: we=%0d busy=%0d left=%0d, required 32 %0d 0",
               we_count - we0, bc, exp_q.size(), REFRESH_CYCLES);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_power_up();
    test_decimal();
    test_no_spurious();
    test_change_mid();
    test_null_name();
    test_reset_mid();
    repeat (10) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: %0d chars never written, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_status_writer.md
# lcd_status_writer

Formats the player initial and current score into a 32-character, two-line status page and streams it to the character LCD controller. It takes `name` (derived from reg17) and the score byte (reg16[12:5]) and drives the controller's `ascii_data` / `lcd_we` / `lcd_reset` inputs. A page is rewritten only after reset or when either input changes. The score is converted to decimal sequentially, and writes are paced for the slow LCD controller.

## Interface
- `GAP`, default 50000 — idle cycles after each `lcd_reset` or `lcd_we` pulse. Legal range 1..2^20−1; the counter is 20 bits.
- `clock` in 1 — system clock (50 MHz).
- `resetn` in 1 — reset, asynchronous, active-low.
- `name` in 16 — two ASCII characters. [15:8] is the first character and [7:0] the second; 8'h00 means blank.
- `score` in 8 — unsigned binary score, 0..255.
- `ascii_data` out 8 — character to the LCD controller.
- `lcd_we` out 1 — one-cycle write strobe; `ascii_data` is valid in the same cycle.
- `lcd_reset` out 1 — one-cycle clear/home strobe to the LCD controller.
- `busy` out 1 — high from refresh start until return to IDLE.

## Operation
- **States:** IDLE, CONVERT, CLEAR, WAIT, SEND.
- **Reset values:** `ascii_data` = 8'h20, `lcd_we` = 0, `lcd_reset` = 0, `busy` = 0, state = IDLE, `pending` flag = 1 (forces a first refresh).
- **IDLE:** start a refresh if `pending` = 1 or {`name`,`score`} differs from the last displayed snapshot.
  - On start, register the snapshot, clear `pending`, set `busy`, go to CONVERT.
  - Input changes during a refresh are ignored. They are picked up in IDLE after the refresh ends.
- **CONVERT:** double-dabble on the snapshot score, exactly 8 cycles, one shift/add-3 per cycle. Produces hundreds, tens and units BCD digits, then goes to CLEAR.
- **CLEAR:** `lcd_reset` = 1 for one cycle, then WAIT with the counter loaded to GAP.
- **WAIT:** count down GAP cycles. Then go to SEND at index k (k starts at 0 after CLEAR), or go to IDLE if k = 32.
- **SEND:** one cycle with `lcd_we` = 1 and `ascii_data` = char(k). Then k increments and the block returns to WAIT.
  - `ascii_data` holds its value until the next SEND.
- **Page map** (k = 0..31):
  - 0–6: "PLAYER " (P,L,A,Y,E,R,space).
  - 7: `name`[15:8]. 8: `name`[7:0]. A 00 byte in either position becomes 8'h20.
  - 9–15: spaces.
  - 16–21: "SCORE ".
  - 22–24: hundreds, tens, units as 8'h30+digit.
    - Leading zeros become 8'h20 (hundreds if 0; tens if hundreds and tens are both 0).
    - Units are always a digit.
  - 25–31: spaces.
- `lcd_we` and `lcd_reset` are never high in the same cycle, and each is never high for two consecutive cycles.
- **Reset mid-refresh:** outputs return to their reset values immediately (asynchronous), k = 0 and `pending` = 1. After release, a full refresh restarts from IDLE.

## Timing
- **Refresh start:** the IDLE cycle that detects the change registers the snapshot. `busy` rises at the following edge.
- **`lcd_reset`:** high in the 9th cycle after `busy` rises (8 CONVERT cycles, then CLEAR).
- **First `lcd_we`:** GAP+1 cycles after the `lcd_reset` cycle.
- **Spacing:** consecutive `lcd_we` pulses are exactly GAP+1 cycles apart.
- **End of refresh:** `busy` falls GAP cycles after the 32nd `lcd_we`, on entry to IDLE.
- **Duration:** a refresh lasts 9 + 32·(GAP+1) + GAP cycles of `busy` high.
- **Back-to-back refreshes:** a new refresh can start on the first IDLE cycle, so `busy` is low for at least 1 cycle between refreshes.

## Test plan
- **Power-up refresh:** GAP=4, `name`=16'h4E47 ("NG"), `score`=0, release `resetn`.
  - Exactly 1 `lcd_reset` and 32 `lcd_we` pulses.
  - Captured page "PLAYER NG       SCORE   0       ".
  - `lcd_we` pulses 5 cycles apart; `busy` high for 173 cycles.
- **Decimal formatting:** with a stable name, step `score` through 5, 40, 100, 255.
  - Digits at k=22..24 are "  5", " 40", "100", "255".
  - Exactly one refresh per change.
- **No spurious writes:** hold the inputs constant for 1000 cycles after a refresh.
  - `lcd_we`, `lcd_reset` and `busy` stay 0.
- **Change mid-refresh:** change `score` 3→9 during the 10th write.
  - The current page completes with "  3".
  - A second refresh follows immediately with "  9".
  - Change 9→12→9 within a single refresh: a follow-up refresh still shows "  9".
- **Null name:** `name`=16'h4100.
  - k=7 is 8'h41 and k=8 is 8'h20.
- **Reset mid-refresh:** assert `resetn` low during the 20th write.
  - Outputs go to their reset values in the same cycle.
  - After release, a full 32-write refresh occurs with the current inputs.
